// File: rtl/iob_2p_asym_fifo.sv
// rtl/iob_2p_asym_fifo.sv - dual-width synchronous FIFO over a two-port asymmetric RAM
//
// Purpose:
//   Single-clock FIFO whose write and read widths may differ by a power-of-two
//   ratio in either direction. Storage is DEPTH words of MIN_W bits. Both
//   pointers count in MIN_W units. A write stores W_RATIO slices and a read
//   fetches R_RATIO slices, in little-endian order.
//
// Optional build macro:
//   IOB_ASYM_FIFO_ERR_EN - adds err_clr, w_ovf and r_unf (sticky over/underflow).
//
// Ports:
//   clk      in   1            clock, all state on rising edge
//   rst_n    in   1            asynchronous active-low reset
//   w_en     in   1            write request
//   w_data   in   W_DATA_W     write data
//   w_full   out  1            cannot accept a W_DATA_W word
//   r_en     in   1            read request
//   r_data   out  R_DATA_W     read data, registered (valid the cycle after the read)
//   r_empty  out  1            fewer than R_RATIO min words stored
//   level    out  ADDR_W+1     occupancy in MIN_W words
//   err_clr  in   1            synchronous clear of sticky flags   (ERR_EN only)
//   w_ovf    out  1            sticky write-while-full flag        (ERR_EN only)
//   r_unf    out  1            sticky read-while-empty flag        (ERR_EN only)

module iob_2p_asym_fifo #(
   parameter int W_DATA_W = 32,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                w_en,
   input  logic [W_DATA_W-1:0] w_data,
   output logic                w_full,
   input  logic                r_en,
   output logic [R_DATA_W-1:0] r_data,
   output logic                r_empty,
   output logic [ADDR_W:0]     level
`ifdef IOB_ASYM_FIFO_ERR_EN
   ,
   input  logic                err_clr,
   output logic                w_ovf,
   output logic                r_unf
`endif
);

   localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
   localparam int W_RATIO = W_DATA_W / MIN_W;
   localparam int R_RATIO = R_DATA_W / MIN_W;
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int LVL_W   = ADDR_W + 1;

   localparam logic [LVL_W-1:0]  W_STEP     = LVL_W'(W_RATIO);
   localparam logic [LVL_W-1:0]  R_STEP     = LVL_W'(R_RATIO);
   localparam logic [LVL_W-1:0]  FULL_THR   = LVL_W'(DEPTH - W_RATIO);
   // A ratio equal to DEPTH truncates to 0, which is the correct modulo step.
   localparam logic [ADDR_W-1:0] W_PTR_STEP = ADDR_W'(W_RATIO);
   localparam logic [ADDR_W-1:0] R_PTR_STEP = ADDR_W'(R_RATIO);

   logic [MIN_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] w_ptr;
   logic [ADDR_W-1:0] r_ptr;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_nxt;
   logic              wr_acc;
   logic              rd_acc;

   // Flags come straight from the registered level, so data written in one
   // cycle is never visible to a read in that same cycle.
   assign w_full  = (level_q > FULL_THR);
   assign r_empty = (level_q < R_STEP);
   assign level   = level_q;

   // rst_n is folded in so requests held during reset leave the RAM untouched.
   assign wr_acc = rst_n && w_en && !w_full;
   assign rd_acc = rst_n && r_en && !r_empty;

   always_comb begin
      level_nxt = level_q;
      if (wr_acc) begin
         level_nxt = level_nxt + W_STEP;
      end
      if (rd_acc) begin
         level_nxt = level_nxt - R_STEP;
      end
   end

   // Write port: slice i of w_data goes to address w_ptr+i. DEPTH is a multiple
   // of W_RATIO and w_ptr only moves in W_RATIO steps, so a word never straddles
   // the wrap point.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < W_RATIO; i++) begin
            mem[w_ptr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
         end
      end
   end

   // Read port: registered read; the oldest slice lands in the LSBs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (rd_acc) begin
         for (int i = 0; i < R_RATIO; i++) begin
            r_data[i*MIN_W +: MIN_W] <= mem[r_ptr + ADDR_W'(i)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         level_q <= '0;
      end else begin
         if (wr_acc) begin
            w_ptr <= w_ptr + W_PTR_STEP;
         end
         if (rd_acc) begin
            r_ptr <= r_ptr + R_PTR_STEP;
         end
         level_q <= level_nxt;
      end
   end

`ifdef IOB_ASYM_FIFO_ERR_EN
   // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_en && w_full) begin
            w_ovf <= 1'b1;
         end else if (err_clr) begin
            w_ovf <= 1'b0;
         end
         if (r_en && r_empty) begin
            r_unf <= 1'b1;
         end else if (err_clr) begin
            r_unf <= 1'b0;
         end
      end
   end
`endif

endmodule
